// File: rtl/idma_axi_burst_legalizer.sv
// Splits one linear copy request into AXI4-legal read and write bursts.
// Bursts never cross a page boundary and never exceed MaxBeats beats.
// Read and write sides advance independently; a new request is accepted
// only after both sides have handed off their last burst.

// One side (read or write) of the legalizer: walks an address/remaining pair
// and presents one registered burst descriptor at a time.
module idma_axi_burst_legalizer_side #(
    parameter int  AddrWidth = 32,
    parameter int  DataWidth = 32,
    parameter int  LenWidth  = 32,
    parameter int  MaxBeats  = 256,
    parameter int  PageSize  = 4096,
    localparam int StrbWidth = DataWidth / 8,
    localparam int OffW      = $clog2(StrbWidth),
    localparam int NbW       = $clog2(MaxBeats * StrbWidth) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] start_addr_i,
    input  logic [LenWidth-1:0]  start_len_i,
    input  logic                 ready_i,
    output logic [AddrWidth-1:0] addr_o,
    output logic [7:0]           len_o,
    output logic [OffW-1:0]      offset_o,
    output logic [OffW-1:0]      tailer_o,
    output logic [NbW-1:0]       num_bytes_o,
    output logic                 last_o,
    output logic                 valid_o,
    output logic                 fin_o
);
    localparam int PgW      = $clog2(PageSize);
    localparam int MaxBytes = MaxBeats * StrbWidth;
    localparam int CalcW    = ((LenWidth > AddrWidth) ? LenWidth : AddrWidth) + 2;

    logic [AddrWidth-1:0] cur_addr_q, cur_addr_d;
    logic [LenWidth-1:0]  remaining_q, remaining_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [7:0]           len_q, len_d;
    logic [OffW-1:0]      offset_q, offset_d;
    logic [OffW-1:0]      tailer_q, tailer_d;
    logic [NbW-1:0]       bytes_q, bytes_d;
    logic                 last_q, last_d;
    logic                 valid_q, valid_d;

    logic [AddrWidth-1:0] calc_addr;
    logic [LenWidth-1:0]  calc_rem;
    logic [CalcW-1:0]     page_room, beat_room, bytes_w;
    logic [NbW-1:0]       bytes_nb, end_nb;
    logic                 advance;

    // Pick the source of the next burst: a fresh request or the running cursor.
    always_comb begin
        calc_addr = start_i ? start_addr_i : cur_addr_q;
        calc_rem  = start_i ? start_len_i  : remaining_q;
    end

    // Size the next burst as the tightest of remaining bytes, page room and beat room.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so each line sees the value
        // computed just above it; bytes_w is refined step by step below.
        page_room = CalcW'(PageSize) - CalcW'(calc_addr[PgW-1:0]);
        beat_room = CalcW'(MaxBytes) - CalcW'(calc_addr[OffW-1:0]);
        bytes_w   = CalcW'(calc_rem);
        if (page_room < bytes_w) bytes_w = page_room;
        if (beat_room < bytes_w) bytes_w = beat_room;
        bytes_nb  = NbW'(bytes_w);
        end_nb    = NbW'(calc_addr[OffW-1:0]) + bytes_nb;
    end

    assign advance = start_i || (valid_q && ready_i && !last_q);

    // Next-state: load a new descriptor on start or on a non-last handshake,
    // drop valid after the last handshake, otherwise hold everything.
    always_comb begin
        // NOTE: every target gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        len_d       = len_q;
        offset_d    = offset_q;
        tailer_d    = tailer_q;
        bytes_d     = bytes_q;
        last_d      = last_q;
        valid_d     = valid_q;
        if (advance) begin
            addr_d      = calc_addr;
            len_d       = 8'(((end_nb + NbW'(StrbWidth - 1)) >> OffW) - NbW'(1));
            offset_d    = calc_addr[OffW-1:0];
            tailer_d    = end_nb[OffW-1:0];
            bytes_d     = bytes_nb;
            last_d      = (CalcW'(calc_rem) == bytes_w);
            valid_d     = 1'b1;
            cur_addr_d  = calc_addr + AddrWidth'(bytes_nb);
            remaining_d = calc_rem - LenWidth'(bytes_nb);
        end else if (valid_q && ready_i && last_q) begin
            valid_d = 1'b0;
        end
    end

    // Descriptor and cursor registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: the reset is asynchronous so valids drop the instant rst_i
        // rises; every register is cleared so no stale burst survives it.
        if (rst_i) begin
            cur_addr_q  <= '0;
            remaining_q <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            offset_q    <= '0;
            tailer_q    <= '0;
            bytes_q     <= '0;
            last_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            offset_q    <= offset_d;
            tailer_q    <= tailer_d;
            bytes_q     <= bytes_d;
            last_q      <= last_d;
            valid_q     <= valid_d;
        end
    end

    assign addr_o      = addr_q;
    assign len_o       = len_q;
    assign offset_o    = offset_q;
    assign tailer_o    = tailer_q;
    assign num_bytes_o = bytes_q;
    assign last_o      = last_q;
    assign valid_o     = valid_q;
    // Side is finished once it is idle or its last burst is handshaking now.
    assign fin_o       = !valid_q || (ready_i && last_q);
endmodule

module idma_axi_burst_legalizer #(
    parameter int  AddrWidth = 32,
    parameter int  DataWidth = 32,
    parameter int  LenWidth  = 32,
    parameter int  MaxBeats  = 256,
    parameter int  PageSize  = 4096,
    localparam int StrbWidth = DataWidth / 8,
    localparam int OffW      = $clog2(StrbWidth),
    localparam int NbW       = $clog2(MaxBeats * StrbWidth) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AddrWidth-1:0] req_src_addr_i,
    input  logic [AddrWidth-1:0] req_dst_addr_i,
    input  logic [LenWidth-1:0]  req_length_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    output logic [AddrWidth-1:0] r_addr_o,
    output logic [7:0]           r_len_o,
    output logic [OffW-1:0]      r_offset_o,
    output logic [OffW-1:0]      r_tailer_o,
    output logic [OffW-1:0]      r_shift_o,
    output logic [NbW-1:0]       r_num_bytes_o,
    output logic                 r_last_o,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [AddrWidth-1:0] w_addr_o,
    output logic [7:0]           w_len_o,
    output logic [OffW-1:0]      w_offset_o,
    output logic [OffW-1:0]      w_tailer_o,
    output logic [OffW-1:0]      w_shift_o,
    output logic [NbW-1:0]       w_num_bytes_o,
    output logic                 w_last_o,
    output logic                 w_valid_o,
    input  logic                 w_ready_i,
    output logic                 busy_o,
    output logic                 done_o
);
    typedef enum logic [1:0] {StIdle, StSplit, StDone} state_e;

    state_e          state_q, state_d;
    logic [OffW-1:0] r_shift_q, r_shift_d;
    logic [OffW-1:0] w_shift_q, w_shift_d;
    logic            accept, start, r_fin, w_fin;

    // Ready is forced low while reset is held, independent of the state register.
    assign req_ready_o = (state_q == StIdle) && !rst_i;
    assign accept      = req_valid_i && req_ready_o;

    // Transfer FSM; shifts are captured once at acceptance and held.
    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        r_shift_d = r_shift_q;
        w_shift_d = w_shift_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    r_shift_d = req_src_addr_i[OffW-1:0];
                    w_shift_d = OffW'(0) - req_dst_addr_i[OffW-1:0];
                    if (req_length_i != '0) begin
                        start   = 1'b1;
                        state_d = StSplit;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StSplit: if (r_fin && w_fin) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and shift registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            r_shift_q <= '0;
            w_shift_q <= '0;
        end else begin
            state_q   <= state_d;
            r_shift_q <= r_shift_d;
            w_shift_q <= w_shift_d;
        end
    end

    idma_axi_burst_legalizer_side #(
        .AddrWidth(AddrWidth), .DataWidth(DataWidth), .LenWidth(LenWidth),
        .MaxBeats(MaxBeats), .PageSize(PageSize)
    ) u_rd (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start),
        .start_addr_i(req_src_addr_i), .start_len_i(req_length_i), .ready_i(r_ready_i),
        .addr_o(r_addr_o), .len_o(r_len_o), .offset_o(r_offset_o), .tailer_o(r_tailer_o),
        .num_bytes_o(r_num_bytes_o), .last_o(r_last_o), .valid_o(r_valid_o), .fin_o(r_fin)
    );

    idma_axi_burst_legalizer_side #(
        .AddrWidth(AddrWidth), .DataWidth(DataWidth), .LenWidth(LenWidth),
        .MaxBeats(MaxBeats), .PageSize(PageSize)
    ) u_wr (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start),
        .start_addr_i(req_dst_addr_i), .start_len_i(req_length_i), .ready_i(w_ready_i),
        .addr_o(w_addr_o), .len_o(w_len_o), .offset_o(w_offset_o), .tailer_o(w_tailer_o),
        .num_bytes_o(w_num_bytes_o), .last_o(w_last_o), .valid_o(w_valid_o), .fin_o(w_fin)
    );

    assign r_shift_o = r_shift_q;
    assign w_shift_o = w_shift_q;
    assign busy_o    = (state_q != StIdle);
    assign done_o    = (state_q == StDone);
endmodule

// File: tb/tb_idma_axi_burst_legalizer.sv
// Self-checking bench for idma_axi_burst_legalizer (32-bit bus, 256 beats, 4 KiB pages).
// Directed cases first, then randomized requests with random ready patterns,
// all compared against a burst-list model built from the splitting rules.
module tb_idma_axi_burst_legalizer;
    localparam int SW = 4;
    localparam int MB = 256;
    localparam int PS = 4096;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  off;
        logic [1:0]  tail;
        logic [10:0] bytes;
        logic        last;
    } burst_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] req_src_addr_i = '0, req_dst_addr_i = '0, req_length_i = '0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] r_addr_o, w_addr_o;
    logic [7:0]  r_len_o, w_len_o;
    logic [1:0]  r_offset_o, r_tailer_o, r_shift_o, w_offset_o, w_tailer_o, w_shift_o;
    logic [10:0] r_num_bytes_o, w_num_bytes_o;
    logic        r_last_o, r_valid_o, w_last_o, w_valid_o;
    logic        r_ready_i = 1'b1, w_ready_i = 1'b1;
    logic        busy_o, done_o;

    idma_axi_burst_legalizer dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_src_addr_i(req_src_addr_i), .req_dst_addr_i(req_dst_addr_i),
        .req_length_i(req_length_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .r_addr_o(r_addr_o), .r_len_o(r_len_o), .r_offset_o(r_offset_o), .r_tailer_o(r_tailer_o),
        .r_shift_o(r_shift_o), .r_num_bytes_o(r_num_bytes_o), .r_last_o(r_last_o),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
        .w_addr_o(w_addr_o), .w_len_o(w_len_o), .w_offset_o(w_offset_o), .w_tailer_o(w_tailer_o),
        .w_shift_o(w_shift_o), .w_num_bytes_o(w_num_bytes_o), .w_last_o(w_last_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int     compared = 0, mismatched = 0;
    int     cyc = 0, acc_cyc = 0, done_cnt = 0, done_cyc = 0;
    int     r_valid_cnt = 0, w_valid_cnt = 0;
    bit     rand_ready = 1'b0, r_force = 1'b1, w_force = 1'b1;
    burst_t r_got[$], w_got[$], exp_r[$], exp_w[$];
    int     r_hs_cyc[$], w_hs_cyc[$];
    logic [1:0] exp_rs, exp_ws;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Ready drivers: forced levels or a coin flip per cycle.
    always @(posedge clk_i) begin
        #1;
        r_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : r_force;
        w_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : w_force;
    end

    // Monitor: on the falling edge, record bursts that will handshake at the next rising edge.
    always @(negedge clk_i) begin
        burst_t b;
        if (!rst_i) begin
            if (r_valid_o) r_valid_cnt++;
            if (w_valid_o) w_valid_cnt++;
            if (r_valid_o && r_ready_i) begin
                b = {r_addr_o, r_len_o, r_offset_o, r_tailer_o, r_num_bytes_o, r_last_o};
                r_got.push_back(b);
                r_hs_cyc.push_back(cyc);
            end
            if (w_valid_o && w_ready_i) begin
                b = {w_addr_o, w_len_o, w_offset_o, w_tailer_o, w_num_bytes_o, w_last_o};
                w_got.push_back(b);
                w_hs_cyc.push_back(cyc);
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    // Reference: peel bursts off the range using the page, beat and length limits.
    task automatic model_side(input longint addr, input longint n, input bit is_w);
        burst_t b;
        longint off, bytes;
        while (n > 0) begin
            off   = addr % SW;
            bytes = n;
            if (PS - (addr % PS) < bytes) bytes = PS - (addr % PS);
            if (MB * SW - off < bytes) bytes = MB * SW - off;
            b.addr  = 32'(addr);
            b.len   = 8'((off + bytes + SW - 1) / SW - 1);
            b.off   = 2'(off);
            b.tail  = 2'((off + bytes) % SW);
            b.bytes = 11'(bytes);
            b.last  = (bytes == n);
            if (is_w) exp_w.push_back(b);
            else      exp_r.push_back(b);
            addr += bytes;
            n    -= bytes;
        end
    endtask

    task automatic start_req(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len);
        r_got.delete(); w_got.delete(); r_hs_cyc.delete(); w_hs_cyc.delete();
        exp_r.delete(); exp_w.delete();
        model_side(longint'(src), longint'(len), 1'b0);
        model_side(longint'(dst), longint'(len), 1'b1);
        exp_rs = 2'(src % SW);
        exp_ws = 2'((SW - (dst % SW)) % SW);
        @(posedge clk_i);
        #1;
        req_src_addr_i = src;
        req_dst_addr_i = dst;
        req_length_i   = len;
        req_valid_i    = 1'b1;
        step();
        acc_cyc = cyc;
        check("req_ready_at_accept", 64'(req_ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start_cnt;
        bit seen;
        start_cnt = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (done_cnt != start_cnt) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            step();
            check("done_one_cycle", 64'(done_o), 64'd0);
            check("idle_after_done", 64'({busy_o, req_ready_o}), 64'b01);
        end
    endtask

    task automatic compare_all(input string name);
        check({name, "_r_count"}, 64'(r_got.size()), 64'(exp_r.size()));
        for (int i = 0; i < exp_r.size() && i < r_got.size(); i++)
            check({name, "_r_burst"}, 64'(r_got[i]), 64'(exp_r[i]));
        check({name, "_w_count"}, 64'(w_got.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < w_got.size(); i++)
            check({name, "_w_burst"}, 64'(w_got[i]), 64'(exp_w[i]));
        check({name, "_shifts"}, 64'({r_shift_o, w_shift_o}), 64'({exp_rs, exp_ws}));
    endtask

    initial begin
        int d0, rv0, wv0;
        logic [31:0] src, dst, len;

        // Reset state
        repeat (3) step();
        check("rst_req_ready", 64'(req_ready_o), 64'd0);
        check("rst_ctrl", 64'({r_valid_o, w_valid_o, busy_o, done_o}), 64'd0);
        check("rst_r_fields", 64'({r_addr_o, r_len_o, r_offset_o, r_tailer_o, r_num_bytes_o, r_last_o, r_shift_o}), 64'd0);
        check("rst_w_fields", 64'({w_addr_o, w_len_o, w_offset_o, w_tailer_o, w_num_bytes_o, w_last_o, w_shift_o}), 64'd0);
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        step();
        check("post_rst_ready", 64'(req_ready_o), 64'd1);

        // Test 1: single 16-byte burst per side
        start_req(32'h0, 32'h0, 32'd16);
        step();
        check("t1_latency", 64'({r_valid_o, w_valid_o, busy_o}), 64'b111);
        wait_done(50);
        compare_all("t1");
        if (r_got.size() > 0)
            check("t1_r0_literal", 64'(r_got[0]), 64'({32'h0, 8'd3, 2'd0, 2'd0, 11'd16, 1'b1}));
        if (r_hs_cyc.size() > 0 && w_hs_cyc.size() > 0)
            check("t1_done_timing", 64'(done_cyc),
                  64'(((r_hs_cyc[$] > w_hs_cyc[$]) ? r_hs_cyc[$] : w_hs_cyc[$]) + 1));

        // Test 2: page crossing on read side, unaligned write
        start_req(32'h0FFE, 32'h2001, 32'd8);
        wait_done(50);
        compare_all("t2");
        if (r_got.size() == 2) begin
            check("t2_r0", 64'(r_got[0]), 64'({32'h0FFE, 8'd0, 2'd2, 2'd0, 11'd2, 1'b0}));
            check("t2_r1", 64'(r_got[1]), 64'({32'h1000, 8'd1, 2'd0, 2'd2, 11'd6, 1'b1}));
        end
        if (w_got.size() == 1)
            check("t2_w0", 64'(w_got[0]), 64'({32'h2001, 8'd2, 2'd1, 2'd1, 11'd8, 1'b1}));
        check("t2_shift_lit", 64'({r_shift_o, w_shift_o}), 64'({2'd2, 2'd3}));

        // Test 3: four max-size bursts per side, back to back
        start_req(32'h0, 32'h4000, 32'h1000);
        wait_done(100);
        compare_all("t3");
        if (r_hs_cyc.size() == 4 && w_hs_cyc.size() == 4) begin
            check("t3_r_b2b", 64'(r_hs_cyc[3] - r_hs_cyc[0]), 64'd3);
            check("t3_w_b2b", 64'(w_hs_cyc[3] - w_hs_cyc[0]), 64'd3);
        end

        // Test 4: zero length
        rv0 = r_valid_cnt;
        wv0 = w_valid_cnt;
        start_req(32'h123, 32'h456, 32'd0);
        wait_done(10);
        check("t4_done_timing", 64'(done_cyc), 64'(acc_cyc + 1));
        check("t4_no_valids", 64'({r_valid_cnt - rv0, w_valid_cnt - wv0}), 64'd0);
        compare_all("t4");

        // Test 5: write side stalled during test 2 request
        w_force = 1'b0;
        step();
        d0 = done_cnt;
        start_req(32'h0FFE, 32'h2001, 32'd8);
        repeat (8) step();
        check("t5_r_drained", 64'({r_got.size(), w_got.size()}), 64'({32'd2, 32'd0}));
        check("t5_w_held", 64'({w_addr_o, w_len_o, w_offset_o, w_tailer_o, w_num_bytes_o, w_last_o, w_valid_o}),
              64'({32'h2001, 8'd2, 2'd1, 2'd1, 11'd8, 1'b1, 1'b1}));
        check("t5_blocked", 64'({req_ready_o, busy_o, r_valid_o}), 64'b010);
        check("t5_no_done", 64'(done_cnt - d0), 64'd0);
        w_force = 1'b1;
        wait_done(20);
        compare_all("t5");

        // Test 6: reset in the middle of test 3, then test 1 again
        start_req(32'h0, 32'h4000, 32'h1000);
        step();
        #1 rst_i = 1'b1;
        #1;
        check("t6_rst_drop", 64'({r_valid_o, w_valid_o, busy_o, req_ready_o, done_o}), 64'd0);
        d0 = done_cnt;
        repeat (2) @(negedge clk_i);
        #2 rst_i = 1'b0;
        repeat (3) step();
        check("t6_no_done", 64'(done_cnt - d0), 64'd0);
        check("t6_ready_back", 64'({req_ready_o, busy_o}), 64'b10);
        start_req(32'h0, 32'h0, 32'd16);
        step();
        check("t6_latency", 64'({r_valid_o, w_valid_o}), 64'b11);
        wait_done(50);
        compare_all("t6");
        if (r_hs_cyc.size() > 0 && w_hs_cyc.size() > 0)
            check("t6_done_timing", 64'(done_cyc),
                  64'(((r_hs_cyc[$] > w_hs_cyc[$]) ? r_hs_cyc[$] : w_hs_cyc[$]) + 1));

        // Randomized requests with random ready patterns
        rand_ready = 1'b1;
        for (int t = 0; t < 25; t++) begin
            src = 32'($urandom_range(0, 255)) * 32'd4096;
            dst = 32'($urandom_range(256, 511)) * 32'd4096;
            case ($urandom_range(0, 2))
                0:       src += 32'($urandom_range(0, 4095));
                1:       src += 32'(4096 - $urandom_range(1, 8));
                default: src += 32'($urandom_range(0, 8));
            endcase
            dst += ($urandom_range(0, 1) == 1) ? 32'(4096 - $urandom_range(1, 8)) : 32'($urandom_range(0, 4095));
            len = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 64)) : 32'($urandom_range(0, 6000));
            start_req(src, dst, len);
            wait_done(3000);
            compare_all("rand");
        end
        rand_ready = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
